fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch front end directly upstream of the hazard unit.
- Owns the PC and drives the instruction-memory request.
- Registers the fetched instruction for decode.
- Predecodes rs1/rs2/rd/branch and generates is_stall, both consumed by the hazard unit.
- Obeys the hazard unit's stall_out and applies branch/jump redirects from execute.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset; must be 4-byte aligned.
- NOP_INSTR, 32'h0000_0013, bubble encoding (addi x0,x0,0) presented when no valid instruction.

Ports:
- clk  in  1  Clock; all state on posedge.
- reset  in  1  Asynchronous, active-high reset.
- stall_in  in  1  Hazard unit stall_out; hold PC and instruction register.
- redirect  in  1  Execute resolved a taken branch/jump this cycle.
- redirect_pc  in  32  Redirect target.
- imem_req  out  1  Fetch request valid.
- imem_addr  out  32  Fetch address (= PC).
- imem_ready  in  1  Memory accepted request; imem_rdata valid same cycle.
- imem_rdata  in  32  Fetched word.
- instr  out  32  Registered instruction to decode.
- instr_pc  out  32  PC of instr.
- instr_valid  out  1  instr is real (not bubble).
- rs1, rs2, rd  out  5 each  Predecoded RegId of instr; 0 when unused.
- branch  out  1  instr is BRANCH/JAL/JALR.
- is_stall  out  1  instr/predecode unchanged since previous cycle (hazard unit must not re-evaluate).

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset values:
  - PC = RESET_PC; instr = NOP_INSTR; instr_pc = RESET_PC.
  - instr_valid = 0; rs1/rs2/rd = 0; branch = 0; is_stall = 0; state = BOOT.
- imem_addr = PC combinationally.
- imem_req = 1 in RUN and MEM_WAIT, 0 in BOOT and whenever stall_in = 1.
- States:
  - BOOT: one cycle after reset release, then -> RUN. Outputs hold reset values.
  - RUN, priority order:
    - redirect: PC <= redirect_pc; instr <= NOP (valid 0); is_stall <= 0; stay RUN.
    - else stall_in: PC and instr regs held; is_stall <= 1.
    - else imem_ready: instr <= imem_rdata; instr_pc <= PC; valid <= 1; PC <= PC+4; is_stall <= 0.
    - else (not ready): instr <= NOP, valid <= 0; -> MEM_WAIT; is_stall <= 0 on entry cycle.
  - MEM_WAIT:
    - PC held; bubble held; is_stall <= 1.
    - redirect (priority): PC <= redirect_pc, -> RUN.
    - imem_ready: capture as in RUN, is_stall <= 0, -> RUN.
- Redirect always beats stall_in. Hazard-unit stalls after a branch are exactly the cycles in which the redirect arrives.
- Wrong-path fetch in the redirect cycle is discarded. Exactly one bubble follows a redirect.
- PC arithmetic is modulo 2^32; PC+4 from 32'hFFFF_FFFC wraps to 0.
- redirect_pc[1:0] is ignored (forced 0).
- Predecode is registered alongside instr, so outputs change together, on the same edge. Decode by opcode[6:0]:
  - R/OP (0110011): rs1, rs2, rd.
  - I (0010011, 0000011, 1100111): rs1, rd.
  - S (0100011) and B (1100011): rs1, rs2; rd = 0.
  - U (0110111, 0010111) and J (1101111): rd only.
  - Unlisted opcodes: all 0.
  - branch = opcode in {1100011, 1101111, 1100111}.
  - Bubble predecodes to all zero.
- Outputs change only on posedge. The hazard unit samples them at negedge.
- Reset mid-operation: all state returns to reset values immediately, regardless of state or pending redirect.

Optional Feature:
- Macro: FETCH_PERF_COUNTERS_EN.
- Defined: adds outputs perf_fetched (32), perf_stall_cycles (32) and perf_redirects (32).
  - perf_fetched increments on each captured valid instruction.
  - perf_stall_cycles increments on each cycle with stall_in = 1 or state MEM_WAIT.
  - perf_redirects increments on each accepted redirect.
  - All counters saturate at 32'hFFFF_FFFF and reset to 0.
- Undefined: ports and logic absent; behaviour otherwise identical.

Decomposition:
- Shared package:
  - Clock, Bool, RegId, Word/Addr (32-bit) typedefs.
  - Opcode constants OPC_OP, OPC_OPIMM, OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC.
  - NOP_INSTR constant.
  - Fetch state enum {BOOT, RUN, MEM_WAIT}.
- One sub-module: fetch_predecoder. Combinational, instr -> rs1/rs2/rd/branch; reusable by decode.

Test Plan:
- Reset with RESET_PC = 0x100, imem_ready = 1:
  - imem_addr = 0x100 after BOOT.
  - Next edge: instr = imem_rdata, instr_pc = 0x100, valid = 1, PC = 0x104.
- Fetch 0x00208133 (add x2,x1,x2) -> rs1 = 1, rs2 = 2, rd = 2, branch = 0.
  - Then fetch 0x00112023 (sw) -> rd = 0, rs1 = 2, rs2 = 1.
- stall_in = 1 for 2 cycles at PC 0x108:
  - imem_req = 0; instr/PC frozen.
  - is_stall = 1 both following cycles, 0 after release.
  - Fetch resumes at 0x108.
- redirect = 1 with redirect_pc = 0x200 while stall_in = 1:
  - Next cycle: instr = NOP, valid = 0, is_stall = 0, imem_addr = 0x200.
  - Following cycle: instr_pc = 0x200.
- imem_ready low 3 cycles:
  - Bubble held; is_stall 0, 1, 1.
  - On ready: capture, is_stall = 0.
  - A redirect mid-wait goes to its target instead.
- Assert reset asynchronously in MEM_WAIT -> outputs immediately at reset values; BOOT then fetch from RESET_PC.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the instruction-fetch front end.
// Used by fetch_stage and fetch_predecoder; decode can reuse the opcode set.
package fetch_stage_pkg;

    typedef logic        clock_t;
    typedef logic        bool_t;
    typedef logic [4:0]  reg_id_t;
    typedef logic [31:0] word_t;
    typedef logic [31:0] addr_t;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    // addi x0,x0,0
    localparam word_t NOP_INSTR_ENC = 32'h0000_0013;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        MEM_WAIT
    } fetch_state_e;

endpackage

// File: rtl/fetch_predecoder.sv
// Combinational register-id and control-flow predecode of one instruction word.
// Unused register fields read as 0 so consumers can compare ids without masking.
module fetch_predecoder
    import fetch_stage_pkg::*;
(
    input  word_t   instr_i,
    output reg_id_t rs1_o,
    output reg_id_t rs2_o,
    output reg_id_t rd_o,
    output bool_t   branch_o
);

    logic [6:0] opcode;
    logic       unused_bits;

    assign opcode      = instr_i[6:0];
    assign unused_bits = ^{instr_i[31:25], instr_i[14:12]};

    always_comb begin
        rs1_o    = '0;
        rs2_o    = '0;
        rd_o     = '0;
        branch_o = 1'b0;
        case (opcode)
            OPC_OP: begin
                rs1_o = instr_i[19:15];
                rs2_o = instr_i[24:20];
                rd_o  = instr_i[11:7];
            end
            OPC_OPIMM, OPC_LOAD, OPC_JALR: begin
                rs1_o = instr_i[19:15];
                rd_o  = instr_i[11:7];
            end
            OPC_STORE, OPC_BRANCH: begin
                rs1_o = instr_i[19:15];
                rs2_o = instr_i[24:20];
            end
            OPC_LUI, OPC_AUIPC, OPC_JAL: begin
                rd_o = instr_i[11:7];
            end
            default: ;
        endcase
        branch_o = (opcode == OPC_BRANCH) || (opcode == OPC_JAL) || (opcode == OPC_JALR);
    end

endmodule

// File: rtl/fetch_stage.sv
// Fetch front end: owns the PC, issues imem requests, registers instr plus predecode.
// Build option FETCH_PERF_COUNTERS_EN adds saturating fetch/stall/redirect counters.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter addr_t RESET_PC  = 32'h0000_0000,
    parameter word_t NOP_INSTR = NOP_INSTR_ENC
) (
    input  clock_t  clk,
    input  bool_t   reset,
    input  bool_t   stall_in,
    input  bool_t   redirect,
    input  addr_t   redirect_pc,
    output bool_t   imem_req,
    output addr_t   imem_addr,
    input  bool_t   imem_ready,
    input  word_t   imem_rdata,
    output word_t   instr,
    output addr_t   instr_pc,
    output bool_t   instr_valid,
    output reg_id_t rs1,
    output reg_id_t rs2,
    output reg_id_t rd,
    output bool_t   branch,
    output bool_t   is_stall
`ifdef FETCH_PERF_COUNTERS_EN
    ,
    output word_t   perf_fetched,
    output word_t   perf_stall_cycles,
    output word_t   perf_redirects
`endif
);

    fetch_state_e state_q;
    addr_t        pc_q;
    word_t        instr_q;
    addr_t        instr_pc_q;
    bool_t        valid_q;
    reg_id_t      rs1_q, rs2_q, rd_q;
    bool_t        branch_q;
    bool_t        is_stall_q;

    reg_id_t      pd_rs1, pd_rs2, pd_rd;
    bool_t        pd_branch;
    addr_t        redirect_tgt;
    bool_t        active;
    bool_t        take_redirect;
    bool_t        take_capture;
    bool_t        take_bubble;

    // Predecode the word being captured so it lands on the same edge as instr.
    fetch_predecoder u_predec (
        .instr_i  (imem_rdata),
        .rs1_o    (pd_rs1),
        .rs2_o    (pd_rs2),
        .rd_o     (pd_rd),
        .branch_o (pd_branch)
    );

    assign redirect_tgt  = redirect_pc & ~32'h3;
    assign active        = (state_q != BOOT);
    assign take_redirect = active && redirect;
    // No request is issued while stalled, so imem_ready is ignored then.
    assign take_capture  = active && !redirect && !stall_in && imem_ready;
    assign take_bubble   = (state_q == RUN) && !redirect && !stall_in && !imem_ready;

    assign imem_req  = active && !stall_in;
    assign imem_addr = pc_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= BOOT;
            pc_q       <= RESET_PC;
            instr_q    <= NOP_INSTR;
            instr_pc_q <= RESET_PC;
            valid_q    <= 1'b0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rd_q       <= '0;
            branch_q   <= 1'b0;
            is_stall_q <= 1'b0;
        end else if (!active) begin
            state_q <= RUN;
        end else if (take_redirect) begin
            state_q    <= RUN;
            pc_q       <= redirect_tgt;
            instr_q    <= NOP_INSTR;
            valid_q    <= 1'b0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rd_q       <= '0;
            branch_q   <= 1'b0;
            is_stall_q <= 1'b0;
        end else if (take_capture) begin
            state_q    <= RUN;
            pc_q       <= pc_q + 32'd4;
            instr_q    <= imem_rdata;
            instr_pc_q <= pc_q;
            valid_q    <= 1'b1;
            rs1_q      <= pd_rs1;
            rs2_q      <= pd_rs2;
            rd_q       <= pd_rd;
            branch_q   <= pd_branch;
            is_stall_q <= 1'b0;
        end else if (take_bubble) begin
            state_q    <= MEM_WAIT;
            instr_q    <= NOP_INSTR;
            valid_q    <= 1'b0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rd_q       <= '0;
            branch_q   <= 1'b0;
            is_stall_q <= 1'b0;
        end else begin
            // Stalled in RUN or still waiting in MEM_WAIT: nothing new for the hazard unit.
            is_stall_q <= 1'b1;
        end
    end

    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = valid_q;
    assign rs1         = rs1_q;
    assign rs2         = rs2_q;
    assign rd          = rd_q;
    assign branch      = branch_q;
    assign is_stall    = is_stall_q;

`ifdef FETCH_PERF_COUNTERS_EN
    word_t fetched_q, stall_cycles_q, redirects_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetched_q      <= '0;
            stall_cycles_q <= '0;
            redirects_q    <= '0;
        end else begin
            if (take_capture && (fetched_q != 32'hFFFF_FFFF))
                fetched_q <= fetched_q + 32'd1;
            if ((stall_in || (state_q == MEM_WAIT)) && (stall_cycles_q != 32'hFFFF_FFFF))
                stall_cycles_q <= stall_cycles_q + 32'd1;
            if (take_redirect && (redirects_q != 32'hFFFF_FFFF))
                redirects_q <= redirects_q + 32'd1;
        end
    end

    assign perf_fetched      = fetched_q;
    assign perf_stall_cycles = stall_cycles_q;
    assign perf_redirects    = redirects_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed-vector bench for fetch_stage; expectations go through a queue to a negedge monitor.
// Each vector lists the inputs for one cycle and the outputs expected during that cycle.
module tb_fetch_stage;

    typedef struct {
        logic        req;
        logic [31:0] addr;
        logic [31:0] instr;
        logic [31:0] ipc;
        logic        valid;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        br;
        logic        st;
        int          id;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall_in;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic [4:0]  rs1, rs2, rd;
    logic        branch;
    logic        is_stall;
`ifdef FETCH_PERF_COUNTERS_EN
    logic [31:0] perf_fetched, perf_stall_cycles, perf_redirects;
`endif

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   vec_id = 0;

    fetch_stage #(.RESET_PC(32'h0000_0100)) dut (
        .clk         (clk),
        .reset       (reset),
        .stall_in    (stall_in),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .rs1         (rs1),
        .rs2         (rs2),
        .rd          (rd),
        .branch      (branch),
        .is_stall    (is_stall)
`ifdef FETCH_PERF_COUNTERS_EN
        ,
        .perf_fetched      (perf_fetched),
        .perf_stall_cycles (perf_stall_cycles),
        .perf_redirects    (perf_redirects)
`endif
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input logic q, input logic [31:0] a, input logic [31:0] i,
                                input logic [31:0] p, input logic v, input logic [4:0] r1,
                                input logic [4:0] r2, input logic [4:0] d, input logic b,
                                input logic s);
        exp_t e;
        e.req = q; e.addr = a; e.instr = i; e.ipc = p; e.valid = v;
        e.rs1 = r1; e.rs2 = r2; e.rd = d; e.br = b; e.st = s; e.id = 0;
        return e;
    endfunction

    task automatic chk(input string name, input int id, input logic [31:0] act,
                       input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL vec%0d %s: got %h expected %h", id, name, act, want);
        end
    endtask

    // Driver: inputs for this cycle, then the outputs expected before the next edge.
    task automatic step(input logic rst, input logic stl, input logic rdr,
                        input logic [31:0] rpc, input logic rdy, input logic [31:0] rdata,
                        input exp_t e);
        exp_t t;
        @(posedge clk);
        #2;
        reset       = rst;
        stall_in    = stl;
        redirect    = rdr;
        redirect_pc = rpc;
        imem_ready  = rdy;
        imem_rdata  = rdata;
        t    = e;
        t.id = vec_id;
        vec_id++;
        exp_q.push_back(t);
    endtask

    // Monitor: compares whenever an expectation is pending.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("imem_req",    e.id, {31'd0, imem_req},    {31'd0, e.req});
            chk("imem_addr",   e.id, imem_addr,            e.addr);
            chk("instr",       e.id, instr,                e.instr);
            chk("instr_pc",    e.id, instr_pc,             e.ipc);
            chk("instr_valid", e.id, {31'd0, instr_valid}, {31'd0, e.valid});
            chk("rs1",         e.id, {27'd0, rs1},         {27'd0, e.rs1});
            chk("rs2",         e.id, {27'd0, rs2},         {27'd0, e.rs2});
            chk("rd",          e.id, {27'd0, rd},          {27'd0, e.rd});
            chk("branch",      e.id, {31'd0, branch},      {31'd0, e.br});
            chk("is_stall",    e.id, {31'd0, is_stall},    {31'd0, e.st});
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    localparam logic [31:0] NOP = 32'h0000_0013;

    initial begin
        reset = 1'b1; stall_in = 1'b0; redirect = 1'b0; redirect_pc = '0;
        imem_ready = 1'b0; imem_rdata = '0;

        //   rst  stl  rdr  rpc           rdy  rdata            req addr          instr         ipc           v  rs1 rs2 rd  br st
        step(1'b1,1'b0,1'b0,32'h0,        1'b1,32'h0,        mk(0,32'h100,       NOP,          32'h100,      0, 0,  0,  0,  0, 0));
        step(1'b0,1'b0,1'b0,32'h0,        1'b1,32'h0,        mk(0,32'h100,       NOP,          32'h100,      0, 0,  0,  0,  0, 0));
        step(1'b0,1'b0,1'b0,32'h0,        1'b1,32'h00208133, mk(1,32'h100,       NOP,          32'h100,      0, 0,  0,  0,  0, 0));
        step(1'b0,1'b0,1'b0,32'h0,        1'b1,32'h00112023, mk(1,32'h104,       32'h00208133, 32'h100,      1, 1,  2,  2,  0, 0));
        step(1'b0,1'b1,1'b0,32'h0,        1'b1,32'hDEADBEEF, mk(0,32'h108,       32'h00112023, 32'h104,      1, 2,  1,  0,  0, 0));
        step(1'b0,1'b1,1'b0,32'h0,        1'b1,32'hDEADBEEF, mk(0,32'h108,       32'h00112023, 32'h104,      1, 2,  1,  0,  0, 1));
        step(1'b0,1'b0,1'b0,32'h0,        1'b1,32'h000000EF, mk(1,32'h108,       32'h00112023, 32'h104,      1, 2,  1,  0,  0, 1));
        // redirect beats stall; target low bits dropped
        step(1'b0,1'b1,1'b1,32'h203,      1'b1,32'h12345678, mk(0,32'h10C,       32'h000000EF, 32'h108,      1, 0,  0,  1,  1, 0));
        step(1'b0,1'b0,1'b0,32'h0,        1'b1,32'h00A00593, mk(1,32'h200,       NOP,          32'h108,      0, 0,  0,  0,  0, 0));
        // three cycles without ready, then capture
        step(1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        mk(1,32'h204,       32'h00A00593, 32'h200,      1, 0,  0,  11, 0, 0));
        step(1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        mk(1,32'h204,       NOP,          32'h200,      0, 0,  0,  0,  0, 0));
        step(1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        mk(1,32'h204,       NOP,          32'h200,      0, 0,  0,  0,  0, 1));
        step(1'b0,1'b0,1'b0,32'h0,        1'b1,32'h00208063, mk(1,32'h204,       NOP,          32'h200,      0, 0,  0,  0,  0, 1));
        // redirect while waiting
        step(1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        mk(1,32'h208,       32'h00208063, 32'h204,      1, 1,  2,  0,  1, 0));
        step(1'b0,1'b0,1'b1,32'h300,      1'b0,32'h0,        mk(1,32'h208,       NOP,          32'h204,      0, 0,  0,  0,  0, 0));
        step(1'b0,1'b0,1'b0,32'h0,        1'b1,32'h000102B7, mk(1,32'h300,       NOP,          32'h204,      0, 0,  0,  0,  0, 0));
        step(1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        mk(1,32'h304,       32'h000102B7, 32'h300,      1, 0,  0,  5,  0, 0));
        // asynchronous reset while in MEM_WAIT, seen before any further edge
        step(1'b1,1'b0,1'b0,32'h0,        1'b0,32'h0,        mk(0,32'h100,       NOP,          32'h100,      0, 0,  0,  0,  0, 0));
        step(1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        mk(0,32'h100,       NOP,          32'h100,      0, 0,  0,  0,  0, 0));
        step(1'b0,1'b0,1'b0,32'h0,        1'b1,32'h0041A303, mk(1,32'h100,       NOP,          32'h100,      0, 0,  0,  0,  0, 0));
        step(1'b0,1'b0,1'b0,32'h0,        1'b1,32'hFFFFFFFF, mk(1,32'h104,       32'h0041A303, 32'h100,      1, 3,  0,  6,  0, 0));
        // PC wrap from the top of the address space
        step(1'b0,1'b0,1'b1,32'hFFFFFFFE, 1'b1,32'h0,        mk(1,32'h108,       32'hFFFFFFFF, 32'h104,      1, 0,  0,  0,  0, 0));
        step(1'b0,1'b0,1'b0,32'h0,        1'b1,32'h000080E7, mk(1,32'hFFFFFFFC,  NOP,          32'h104,      0, 0,  0,  0,  0, 0));
        step(1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        mk(1,32'h0,         32'h000080E7, 32'hFFFFFFFC, 1, 1,  0,  1,  1, 0));
        step(1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        mk(1,32'h0,         NOP,          32'hFFFFFFFC, 0, 0,  0,  0,  0, 0));

        for (int k = 0; k < 4 && exp_q.size() > 0; k++) begin
            @(negedge clk);
            #1;
        end
        if (exp_q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
